// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: mnemonics, opcodes and instruction formats shared by encoder and decoder.
package mips_isa_pkg;
  typedef enum logic [4:0] {
    RTYPE, LW, SW, BEQ, ADDI, ORI, J, BNE, LH, LB, LBU, ANDI, JAL, LUI, XORI, BLEZ, SLTI, JR
  } mnem_t;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;
  function automatic fmt_t fmt_of(mnem_t m);
    return (m == RTYPE || m == JR) ? FMT_R : (m == J || m == JAL) ? FMT_J : FMT_I;
  endfunction
endpackage

// File: rtl/instr_packer.sv
// instr_packer: combinational mnemonic + fields -> 32-bit machine word and legality flag.
module instr_packer
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);
  mnem_t m;
  fmt_t fmt;
  logic [5:0] op;
  assign m = mnem_t'(mnem);
  assign fmt = fmt_of(m);
  assign legal = mnem <= 5'(JR);
  always_comb begin
    op = OP_RTYPE;
    case (m)
      LW:      op = OP_LW;
      SW:      op = OP_SW;
      BEQ:     op = OP_BEQ;
      BNE:     op = OP_BNE;
      ADDI:    op = OP_ADDI;
      ORI:     op = OP_ORI;
      ANDI:    op = OP_ANDI;
      XORI:    op = OP_XORI;
      SLTI:    op = OP_SLTI;
      LH:      op = OP_LH;
      LB:      op = OP_LB;
      LBU:     op = OP_LBU;
      LUI:     op = OP_LUI;
      BLEZ:    op = OP_BLEZ;
      J:       op = OP_J;
      JAL:     op = OP_JAL;
      default: op = OP_RTYPE;
    endcase
  end
  // LUI has no source register and BLEZ compares against zero, so those fields are forced
  assign word = !legal ? '0 :
                m == RTYPE ? {OP_RTYPE, rs, rt, rd, 5'd0, funct} :
                m == JR ? {OP_RTYPE, rs, 15'd0, FUNCT_JR} :
                fmt == FMT_J ? {op, target} :
                {op, m == LUI ? 5'd0 : rs, m == BLEZ ? 5'd0 : rt, imm};
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic instructions and writes them to consecutive imem words.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] word;
  logic legal, fire, write;
  instr_packer u_packer (
    .mnem(in_mnem), .rs(in_rs), .rt(in_rt), .rd(in_rd), .funct(in_funct),
    .imm(in_imm), .target(in_target), .word(word), .legal(legal)
  );
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign fire = in_valid && in_ready;
  assign write = fire && legal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= ADDR_W'(BASE_ADDR);
      count <= '0;
      err <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= write;
      if (write) begin
        imem_addr <= ptr;
        imem_wdata <= word;
        ptr <= ptr + 1'b1;
        count <= count + 1'b1;
      end
      if (fire && !legal) err <= 1'b1;
      // the DEPTH-th write closes the session so no address is written twice
      if (state == RUN && (finish || (write && count == (ADDR_W+1)'(DEPTH-1)))) state <= DONE;
      if (state != RUN && start) begin
        state <= RUN;
        ptr <= ADDR_W'(BASE_ADDR);
        count <= '0;
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven vectors with a write scoreboard on two loader sizes.
module tb_instr_encoder_loader;
  import mips_isa_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, start_a, start_b, finish, in_valid;
  logic [4:0] in_mnem, in_rs, in_rt, in_rd;
  logic [5:0] in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic rdy_a, we_a, busy_a, done_a, err_a;
  logic [5:0] addr_a;
  logic [31:0] wd_a;
  logic [6:0] cnt_a;
  logic rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [31:0] wd_b;
  logic [2:0] cnt_b;
  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .finish(finish), .in_valid(in_valid), .in_ready(rdy_a),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .count(cnt_a), .busy(busy_a), .done(done_a), .err(err_a)
  );
  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .finish(finish), .in_valid(in_valid), .in_ready(rdy_b),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .count(cnt_b), .busy(busy_b), .done(done_b), .err(err_b)
  );
  typedef struct {logic [4:0] mnem; logic [4:0] rs, rt, rd; logic [5:0] funct; logic [15:0] imm; logic [25:0] target; logic [31:0] word;} vec_t;
  typedef struct {logic [5:0] addr; logic [31:0] data;} wr_t;
  vec_t tbl[18];
  wr_t qa[$], qb[$], ea, eb;
  int wcyc[$];
  int checks = 0, failures = 0, cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(vec_t v);
    in_mnem = v.mnem; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_funct = v.funct; in_imm = v.imm; in_target = v.target; in_valid = 1'b1;
  endtask
  always @(negedge clk) begin
    if (we_a) begin
      wcyc.push_back(cyc_n);
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write_a addr=%h data=%h expected=none", addr_a, wd_a);
      end else begin
        ea = qa.pop_front();
        chk("addr_a", 64'(addr_a), 64'(ea.addr));
        chk("data_a", 64'(wd_a), 64'(ea.data));
      end
    end
    if (we_b) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write_b addr=%h data=%h expected=none", addr_b, wd_b);
      end else begin
        eb = qb.pop_front();
        chk("addr_b", 64'(addr_b), 64'(eb.addr));
        chk("data_b", 64'(wd_b), 64'(eb.data));
      end
    end
  end
  initial begin
    tbl[0]  = '{ADDI,  5'd0,  5'd8,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h20080005};
    tbl[1]  = '{LW,    5'd8,  5'd9,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8D090004};
    tbl[2]  = '{RTYPE, 5'd8,  5'd9,  5'd10, 6'h20, 16'h0000, 26'h0,       32'h01095020};
    tbl[3]  = '{J,     5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      32'h08000010};
    tbl[4]  = '{JR,    5'd31, 5'd5,  5'd6,  6'h3F, 16'h1234, 26'h0,       32'h03E00008};
    tbl[5]  = '{LUI,   5'd3,  5'd4,  5'd0,  6'h00, 16'h1234, 26'h0,       32'h3C041234};
    tbl[6]  = '{BLEZ,  5'd5,  5'd7,  5'd0,  6'h00, 16'hFFFE, 26'h0,       32'h18A0FFFE};
    tbl[7]  = '{SW,    5'd29, 5'd31, 5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008};
    tbl[8]  = '{BNE,   5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1422FFFF};
    tbl[9]  = '{JAL,   5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
    tbl[10] = '{ORI,   5'd2,  5'd3,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h344300FF};
    tbl[11] = '{BEQ,   5'd4,  5'd5,  5'd0,  6'h00, 16'h0003, 26'h0,       32'h10850003};
    tbl[12] = '{LB,    5'd6,  5'd7,  5'd0,  6'h00, 16'h0001, 26'h0,       32'h80C70001};
    tbl[13] = '{LBU,   5'd6,  5'd7,  5'd0,  6'h00, 16'h0001, 26'h0,       32'h90C70001};
    tbl[14] = '{LH,    5'd6,  5'd7,  5'd0,  6'h00, 16'h0001, 26'h0,       32'h84C70001};
    tbl[15] = '{ANDI,  5'd1,  5'd1,  5'd0,  6'h00, 16'hF0F0, 26'h0,       32'h3021F0F0};
    tbl[16] = '{XORI,  5'd1,  5'd1,  5'd0,  6'h00, 16'hF0F0, 26'h0,       32'h3821F0F0};
    tbl[17] = '{SLTI,  5'd1,  5'd1,  5'd0,  6'h00, 16'hF0F0, 26'h0,       32'h2821F0F0};
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0; finish = 0; in_valid = 0;
    in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_funct = 0; in_imm = 0; in_target = 0;
    repeat (3) tick();
    rst_a = 0; rst_b = 0;
    tick();
    chk("reset_a", 64'({rdy_a, we_a, busy_a, done_a, err_a, addr_a, wd_a, cnt_a}), 64'h0);
    chk("reset_b", 64'({rdy_b, we_b, busy_b, done_b, err_b, addr_b, wd_b, cnt_b}), 64'h0);
    // back-to-back stream of every legal mnemonic
    start_a = 1; tick(); start_a = 0;
    chk("busy_a_run", 64'({busy_a, rdy_a, done_a}), 64'b110);
    for (int i = 0; i < 18; i++) begin
      put(tbl[i]);
      qa.push_back('{6'(i), tbl[i].word});
      tick();
    end
    in_valid = 0;
    tick();
    chk("count_a_stream", 64'(cnt_a), 64'd18);
    chk("qa_drained_stream", 64'(qa.size()), 64'd0);
    if (wcyc.size() < 18) begin
      checks++; failures++;
      $display("FAIL stream_writes actual=%0d required=18", wcyc.size());
    end else chk("no_gaps", 64'(wcyc[wcyc.size()-1] - wcyc[wcyc.size()-18]), 64'd17);
    // illegal mnemonic mid-stream
    put(tbl[0]); qa.push_back('{6'd18, tbl[0].word}); tick();
    put(tbl[1]); in_mnem = 5'd25; tick();
    chk("err_set", 64'(err_a), 64'd1);
    put(tbl[1]); qa.push_back('{6'd19, tbl[1].word}); tick();
    in_valid = 0; tick();
    chk("count_after_illegal", 64'(cnt_a), 64'd20);
    chk("qa_drained_illegal", 64'(qa.size()), 64'd0);
    repeat (3) tick();
    chk("err_sticky", 64'(err_a), 64'd1);
    finish = 1; tick(); finish = 0;
    chk("finish_done", 64'({done_a, rdy_a, busy_a, err_a}), 64'b1001);
    start_a = 1; tick(); start_a = 0;
    chk("restart_clear", 64'({busy_a, err_a, cnt_a}), 64'({1'b1, 1'b0, 7'd0}));
    // finish together with a handshake
    put(tbl[2]); finish = 1; qa.push_back('{6'd0, tbl[2].word}); tick();
    in_valid = 0; finish = 0;
    chk("finish_hs_state", 64'({done_a, rdy_a, cnt_a}), 64'({1'b1, 1'b0, 7'd1}));
    tick();
    chk("qa_drained_finish", 64'(qa.size()), 64'd0);
    start_a = 1; tick(); start_a = 0;
    chk("restart_count", 64'(cnt_a), 64'd0);
    put(tbl[3]); qa.push_back('{6'd0, tbl[3].word}); tick();
    in_valid = 0; tick();
    chk("qa_drained_restart", 64'(qa.size()), 64'd0);
    // reset coinciding with an offered handshake squashes the write
    put(tbl[4]); rst_a = 1; tick();
    rst_a = 0; in_valid = 0;
    chk("reset_squash", 64'({rdy_a, we_a, busy_a, done_a, err_a, addr_a, wd_a, cnt_a}), 64'h0);
    tick();
    chk("reset_no_late_we", 64'(we_a), 64'd0);
    // full session on the 4-word loader: fifth input is held off
    start_b = 1; tick(); start_b = 0;
    for (int i = 0; i < 5; i++) begin
      put(tbl[i + 5]);
      if (i < 4) qb.push_back('{6'(i), tbl[i + 5].word});
      else chk("rdy_b_full", 64'(rdy_b), 64'd0);
      tick();
    end
    in_valid = 0;
    chk("full_b_state", 64'({done_b, rdy_b, busy_b, cnt_b}), 64'({1'b1, 1'b0, 1'b0, 3'd4}));
    tick();
    chk("qb_drained", 64'(qb.size()), 64'd0);
    repeat (2) tick();
    chk("qa_final", 64'(qa.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
